// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the text-mode line prefetcher
package vga_pkg;
    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 25;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
    typedef struct packed {
        logic [7:0] glyph;
        logic [3:0] fg;
        logic [3:0] bg;
        logic       cursor;
    } line_entry_t;
endpackage

// File: rtl/vga_line_buffer.sv
// vga_line_buffer: two banks of one text line, one write port and one registered read port
module vga_line_buffer
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic        wr_bank,
    input  logic [6:0]  wr_col,
    input  line_entry_t wr_data,
    input  logic        rd_bank,
    input  logic [6:0]  rd_col,
    output line_entry_t rd_data
);
    line_entry_t mem [2][TEXT_COLS];
    // write port; contents are deliberately left out of reset
    always_ff @(posedge clk)
        if (we) mem[wr_bank][wr_col] <= wr_data;
    // registered read; columns past the end of the line read as blank
    always_ff @(posedge clk)
        if (!reset_n) rd_data <= '0;
        else rd_data <= (rd_col < 7'(TEXT_COLS)) ? mem[rd_bank][rd_col] : '0;
endmodule

// File: rtl/vga_line_prefetch.sv
// vga_line_prefetch: fetches one text row from VRAM into a double-buffered line; optional VGA_CURSOR_BLINK_EN blinks the cursor
module vga_line_prefetch
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_start,
    input  logic [4:0]  text_row,
    input  logic        buf_swap,
    output logic        vram_req,
    output logic [10:0] vram_addr,
    input  logic        vram_ack,
    input  logic [15:0] vram_data,
    input  logic [10:0] cursor_pos,
    input  logic        cursor_enabled,
    input  logic        vsync,
    input  logic [6:0]  rd_col,
    output logic [7:0]  rd_glyph,
    output logic [3:0]  rd_fg,
    output logic [3:0]  rd_bg,
    output logic        rd_cursor,
    output logic        fetch_busy,
    output logic        underrun
);
    fetch_state_t state, state_nx;
    logic [4:0]  row;
    logic [6:0]  col;
    logic        bank_sel, cursor_en_q, we, set_underrun, last_col, blink_on;
    line_entry_t wr_entry, rd_entry;

    assign last_col   = col == 7'(TEXT_COLS - 1);
    assign vram_addr  = (state == IDLE) ? '0 : 11'(row) * 11'(TEXT_COLS) + 11'(col);
    assign fetch_busy = state != IDLE;
    assign wr_entry   = '{glyph: vram_data[7:0], fg: vram_data[11:8], bg: vram_data[15:12],
                          cursor: vram_addr == cursor_pos};

    // state register
    always_ff @(posedge clk)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    // next state and request/write strobes; a swap that lands on the final ack is a clean finish
    always_comb begin
        state_nx     = state;
        vram_req     = 1'b0;
        we           = 1'b0;
        set_underrun = 1'b0;
        case (state)
            IDLE: state_nx = fetch_start ? FETCH : IDLE;
            FETCH: begin
                vram_req = 1'b1;
                if (buf_swap && !(vram_ack && last_col)) begin
                    set_underrun = 1'b1;
                    state_nx     = vram_ack ? IDLE : DRAIN;
                end else if (vram_ack) begin
                    we       = 1'b1;
                    state_nx = last_col ? IDLE : FETCH;
                end
            end
            DRAIN: begin
                vram_req = 1'b1;
                state_nx = vram_ack ? IDLE : DRAIN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // row/column tracking, bank select, sticky underrun and the cursor enable aligned to the read
    always_ff @(posedge clk)
        if (!reset_n) begin
            row         <= '0;
            col         <= '0;
            bank_sel    <= 1'b0;
            underrun    <= 1'b0;
            cursor_en_q <= 1'b0;
        end else begin
            if (state == IDLE && fetch_start) begin
                row <= text_row;
                col <= '0;
            end else if (we) begin
                col <= col + 7'd1;
            end
            bank_sel    <= bank_sel ^ buf_swap;
            underrun    <= underrun | set_underrun;
            cursor_en_q <= cursor_enabled;
        end

`ifdef VGA_CURSOR_BLINK_EN
    logic       vsync_q;
    logic [4:0] blink_cnt;
    // count frames on vsync rising edges; the top bit gives 16 frames on, 16 off
    always_ff @(posedge clk)
        if (!reset_n) begin
            vsync_q   <= 1'b0;
            blink_cnt <= '0;
        end else begin
            vsync_q <= vsync;
            if (vsync && !vsync_q) blink_cnt <= blink_cnt + 5'd1;
        end
    assign blink_on = ~blink_cnt[4];
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
    assign blink_on     = 1'b1;
`endif

    vga_line_buffer u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .wr_bank (~bank_sel),
        .wr_col  (col),
        .wr_data (wr_entry),
        .rd_bank (bank_sel),
        .rd_col  (rd_col),
        .rd_data (rd_entry)
    );

    assign rd_glyph  = rd_entry.glyph;
    assign rd_fg     = rd_entry.fg;
    assign rd_bg     = rd_entry.bg;
    assign rd_cursor = rd_entry.cursor & cursor_en_q & blink_on;
endmodule

// File: tb/tb_vga_line_prefetch.sv
// tb_vga_line_prefetch: directed bench with a line-level reference model for vga_line_prefetch
module tb_vga_line_prefetch;
    logic        clk = 0, reset_n = 0, fetch_start = 0, buf_swap = 0, vram_ack = 0;
    logic        cursor_enabled = 0, vsync = 0;
    logic [4:0]  text_row = 0;
    logic [15:0] vram_data = 0;
    logic [10:0] cursor_pos = 0;
    logic [6:0]  rd_col = 0;
    logic        vram_req, rd_cursor, fetch_busy, underrun;
    logic [10:0] vram_addr;
    logic [7:0]  rd_glyph;
    logic [3:0]  rd_fg, rd_bg;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    vga_line_prefetch dut (
        .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .text_row(text_row),
        .buf_swap(buf_swap), .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack),
        .vram_data(vram_data), .cursor_pos(cursor_pos), .cursor_enabled(cursor_enabled),
        .vsync(vsync), .rd_col(rd_col), .rd_glyph(rd_glyph), .rd_fg(rd_fg), .rd_bg(rd_bg),
        .rd_cursor(rd_cursor), .fetch_busy(fetch_busy), .underrun(underrun)
    );

    function automatic logic [15:0] vword(input logic [10:0] a);
        return 16'(a) * 16'd40503 ^ 16'h5a3c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // VRAM responder: acknowledges every third cycle of an outstanding request
    int          wcnt = 0, ack_total = 0;
    logic [10:0] addr_q [$];
    initial forever begin
        @(posedge clk);
        #1;
        vram_ack = 0;
        if (reset_n && vram_req) begin
            wcnt++;
            if (wcnt == 3) begin
                wcnt = 0;
                vram_ack = 1;
                vram_data = vword(vram_addr);
                ack_total++;
                addr_q.push_back(vram_addr);
            end
        end else wcnt = 0;
    end

    // reference model: two banks of line words, the current fetch position and flags
    logic [16:0] mm [2][80];
    bit          mv [2][80];
    bit          m_ok = 0, m_busy = 0, m_drain = 0, m_sel = 0, m_ur = 0, m_vs = 0, m_craw = 0, m_blink_on = 1;
    logic [4:0]  m_row = 0, m_blink = 0;
    int          m_col = 0;
    logic [10:0] m_addr;
    bit          e_req, e_busy, e_ur, e_rd_known, e_cur;
    logic [10:0] e_addr;
    logic [15:0] e_word;

    always @(negedge clk) begin
        if (m_ok) begin
            chk("vram_req", vram_req, e_req);
            chk("fetch_busy", fetch_busy, e_busy);
            chk("underrun", underrun, e_ur);
            if (e_req) chk("vram_addr", vram_addr, e_addr);
            if (e_rd_known) begin
                chk("rd_glyph", rd_glyph, e_word[7:0]);
                chk("rd_fg", rd_fg, e_word[11:8]);
                chk("rd_bg", rd_bg, e_word[15:12]);
                chk("rd_cursor", rd_cursor, e_cur);
            end
        end
        if (!reset_n) begin
            m_ok = 1; m_busy = 0; m_drain = 0; m_col = 0; m_sel = 0; m_ur = 0;
            m_vs = 0; m_blink = 0; e_rd_known = 1; e_word = 0; e_cur = 0;
        end else begin
            m_addr = 11'(m_row * 80 + m_col);
            if (rd_col < 80) begin
                e_rd_known = mv[m_sel][rd_col];
                e_word = mm[m_sel][rd_col][16:1];
                m_craw = mm[m_sel][rd_col][0];
            end else begin
                e_rd_known = 1; e_word = 0; m_craw = 0;
            end
            if (vsync && !m_vs) m_blink = m_blink + 5'd1;
            m_vs = vsync;
`ifdef VGA_CURSOR_BLINK_EN
            m_blink_on = m_blink < 16;
`else
            m_blink_on = 1;
`endif
            e_cur = m_craw && cursor_enabled && m_blink_on;
            if (m_busy && !m_drain) begin
                if (buf_swap && !(vram_ack && m_col == 79)) begin
                    m_ur = 1;
                    if (vram_ack) m_busy = 0; else m_drain = 1;
                end else if (vram_ack) begin
                    mm[!m_sel][m_col] = {vram_data, m_addr == cursor_pos};
                    mv[!m_sel][m_col] = 1;
                    if (m_col == 79) m_busy = 0;
                    m_col++;
                end
            end else if (m_drain) begin
                if (vram_ack) begin m_busy = 0; m_drain = 0; end
            end else if (fetch_start) begin
                m_busy = 1; m_row = text_row; m_col = 0;
            end
            if (buf_swap) m_sel = !m_sel;
        end
        e_req = m_busy; e_busy = m_busy; e_ur = m_ur;
        e_addr = 11'(m_row * 80 + m_col);
    end

    task automatic do_fetch(input int r);
        @(posedge clk); #1 text_row = 5'(r); fetch_start = 1;
        @(posedge clk); #1 fetch_start = 0;
    endtask

    task automatic swap();
        @(posedge clk); #1 buf_swap = 1;
        @(posedge clk); #1 buf_swap = 0;
    endtask

    task automatic read_at(input int c);
        @(posedge clk); #1 rd_col = 7'(c);
        @(posedge clk); #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (fetch_busy && n < 2000);
        chk("wait_idle timeout", fetch_busy, 0);
    endtask

    task automatic wait_acks(input int target);
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (ack_total < target && n < 2000);
        chk("wait_acks timeout", int'(ack_total >= target), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int base, bacc, ok, cnt, pos, expc;
        logic [15:0] w;
        repeat (3) @(posedge clk);
        #2;
        chk("reset vram_req", vram_req, 0);
        chk("reset vram_addr", vram_addr, 0);
        chk("reset fetch_busy", fetch_busy, 0);
        chk("reset rd outputs", {rd_glyph, rd_fg, rd_bg, rd_cursor}, 0);
        @(posedge clk); #1 reset_n = 1; cursor_pos = 170; cursor_enabled = 1;

        base = addr_q.size();
        do_fetch(2);
        wait_idle();
        chk("row2 request count", addr_q.size() - base, 80);
        ok = 1;
        for (int i = 0; i < 80 && base + i < addr_q.size(); i++) if (addr_q[base + i] != 11'(160 + i)) ok = 0;
        chk("row2 addresses 160..239", ok, 1);
        swap();
        read_at(5);
        w = vword(165);
        chk("col5 glyph", rd_glyph, w[7:0]);
        chk("col5 fg", rd_fg, w[11:8]);
        chk("col5 bg", rd_bg, w[15:12]);

        cnt = 0; pos = -1;
        for (int c = 0; c < 80; c++) begin read_at(c); if (rd_cursor) begin cnt++; pos = c; end end
        chk("cursor count", cnt, 1);
        chk("cursor column", pos, 10);
        @(posedge clk); #1 cursor_enabled = 0;
        cnt = 0;
        for (int c = 0; c < 80; c++) begin read_at(c); if (rd_cursor) cnt++; end
        chk("cursor disabled count", cnt, 0);
        @(posedge clk); #1 cursor_enabled = 1;
        read_at(100);
        chk("rd_col 100 blank", {rd_glyph, rd_fg, rd_bg, rd_cursor}, 0);

        do_fetch(3);
        wait_idle();
        swap();
        bacc = ack_total;
        do_fetch(5);
        wait_acks(bacc + 40);
        @(posedge clk); #1 buf_swap = 1;
        @(posedge clk); #1 buf_swap = 0;
        wait_idle();
        chk("underrun set", underrun, 1);
        chk("acks around underrun", ack_total - bacc, 41);
        read_at(20);
        w = vword(420);
        chk("underrun col20 new", rd_glyph, w[7:0]);
        read_at(40);
        w = vword(200);
        chk("underrun col40 old", rd_glyph, w[7:0]);

        bacc = ack_total;
        do_fetch(7);
        wait_acks(bacc + 5);
        @(posedge clk); #1 text_row = 9; fetch_start = 1;
        @(posedge clk); #1 fetch_start = 0;
        @(posedge clk); #2;
        chk("ignored start row", vram_addr / 80, 7);
        wait_acks(bacc + 30);
        @(posedge clk); #1 reset_n = 0;
        @(posedge clk); @(posedge clk); #2;
        chk("mid-fetch reset vram_req", vram_req, 0);
        chk("mid-fetch reset busy", fetch_busy, 0);
        chk("mid-fetch reset underrun", underrun, 0);
        chk("mid-fetch reset rd", {rd_glyph, rd_fg, rd_bg, rd_cursor}, 0);
        @(posedge clk); #1 reset_n = 1;

        base = addr_q.size();
        bacc = ack_total;
        do_fetch(31);
        wait_acks(bacc + 79);
        repeat (3) @(posedge clk);
        #1 buf_swap = 1;
        @(posedge clk); #1 buf_swap = 0;
        wait_idle();
        chk("row31 total acks", ack_total - bacc, 80);
        if (addr_q.size() >= base + 80) begin
            chk("row31 first addr wraps", addr_q[base], 432);
            chk("row31 last addr wraps", addr_q[base + 79], 511);
        end
        chk("final-ack swap underrun", underrun, 0);
        read_at(79);
        w = vword(511);
        chk("final-ack swap col79", rd_glyph, w[7:0]);
        read_at(0);
        w = vword(432);
        chk("final-ack swap col0", rd_glyph, w[7:0]);

        cursor_pos = 170;
        do_fetch(2);
        wait_idle();
        swap();
        for (int f = 0; f < 32; f++) begin
            read_at(10);
`ifdef VGA_CURSOR_BLINK_EN
            expc = f < 16 ? 1 : 0;
`else
            expc = 1;
`endif
            chk($sformatf("blink frame %0d", f), rd_cursor, expc);
            @(posedge clk); #1 vsync = 1;
            @(posedge clk); #1 vsync = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
